// File: rtl/code_loader_pkg.sv
// Shared types and constants for the code memory loader.
package code_loader_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned LANES  = WORD_W / BYTE_W;

  localparam logic [BYTE_W-1:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    DATA,
    WRITE,
    CHECK,
    DONE,
    ERR
  } state_e;

  typedef logic [1:0] lane_t;

endpackage

// File: rtl/code_loader_word_assembler.sv
// Packs a stream of bytes into 32-bit little-endian words; the first byte
// lands in bits [7:0]. o_word_c/o_word_ready_c already include the current byte.
module word_assembler
  import code_loader_pkg::*;
(
  input  logic              clk,
  input  logic              nreset,
  input  logic              i_clear,
  input  logic              i_valid,
  input  logic [BYTE_W-1:0] i_byte,
  output logic [WORD_W-1:0] o_word_c,
  output logic              o_word_ready_c
);

  lane_t                     r_lane;
  logic [WORD_W-BYTE_W-1:0]  r_shift;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_lane  <= '0;
      r_shift <= '0;
    end else if (i_clear) begin
      r_lane  <= '0;
      r_shift <= '0;
    end else if (i_valid) begin
      r_lane  <= r_lane + lane_t'(1);
      r_shift <= {i_byte, r_shift[WORD_W-BYTE_W-1:BYTE_W]};
    end
  end

  // Earlier bytes have been shifted down, so the newest byte is the top lane.
  assign o_word_c       = {i_byte, r_shift};
  assign o_word_ready_c = i_valid && (r_lane == lane_t'(LANES - 1));

endmodule

// File: rtl/code_loader.sv
// Loads framed byte images into CPU code memory and holds the CPU in reset
// until a complete image is present. Optional checksum: CODE_LOADER_CHECKSUM_EN.
module code_loader
  import code_loader_pkg::*;
#(
  parameter int unsigned CODE_WORDS      = 8,
  parameter int unsigned CODE_ADDR_WIDTH = $clog2(CODE_WORDS),
  parameter logic [7:0]  SYNC_BYTE       = SYNC_BYTE_DEFAULT
) (
  input  logic                       clk,
  input  logic                       nreset,
  input  logic                       in_valid,
  input  logic [BYTE_W-1:0]          in_data,
  output logic                       in_ready,
  output logic                       mem_we,
  output logic [CODE_ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_W-1:0]          mem_wdata,
  output logic                       cpu_nreset,
  output logic                       done,
  output logic                       error
);

  state_e                     r_state, w_state_next;
  logic [BYTE_W-1:0]          r_count, w_count_next;
  logic [CODE_ADDR_WIDTH-1:0] r_word_idx, w_word_idx_next;
  logic [CODE_ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr_next;
  logic [WORD_W-1:0]          r_mem_wdata, w_mem_wdata_next;
  logic                       r_mem_we, w_mem_we_next;
  logic                       r_in_ready, r_cpu_nreset, r_done, r_error;
`ifdef CODE_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0]          r_csum, w_csum_next;
`endif

  logic                       w_xfer, w_is_sync, w_bad_count, w_last_word;
  logic                       w_asm_clear, w_asm_valid, w_word_ready_c;
  logic [WORD_W-1:0]          w_word_c;

  assign w_xfer      = in_valid && r_in_ready;
  assign w_is_sync   = (in_data == SYNC_BYTE);
  assign w_bad_count = (in_data == '0) || (32'(in_data) > CODE_WORDS);
  assign w_last_word = (BYTE_W'(r_word_idx) == (r_count - BYTE_W'(1)));
  assign w_asm_clear = (r_state == COUNT);
  assign w_asm_valid = w_xfer && (r_state == DATA);

  word_assembler u_asm (
    .clk            (clk),
    .nreset         (nreset),
    .i_clear        (w_asm_clear),
    .i_valid        (w_asm_valid),
    .i_byte         (in_data),
    .o_word_c       (w_word_c),
    .o_word_ready_c (w_word_ready_c)
  );

  // State register; flag outputs are registered decodes of the next state.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state      <= IDLE;
      r_count      <= '0;
      r_word_idx   <= '0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_in_ready   <= 1'b0;
      r_cpu_nreset <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
`ifdef CODE_LOADER_CHECKSUM_EN
      r_csum       <= '0;
`endif
    end else begin
      r_state      <= w_state_next;
      r_count      <= w_count_next;
      r_word_idx   <= w_word_idx_next;
      r_mem_we     <= w_mem_we_next;
      r_mem_addr   <= w_mem_addr_next;
      r_mem_wdata  <= w_mem_wdata_next;
      r_in_ready   <= (w_state_next != WRITE);
      r_cpu_nreset <= (w_state_next == DONE);
      r_done       <= (w_state_next == DONE);
      r_error      <= (w_state_next == ERR);
`ifdef CODE_LOADER_CHECKSUM_EN
      r_csum       <= w_csum_next;
`endif
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_count_next     = r_count;
    w_word_idx_next  = r_word_idx;
    w_mem_we_next    = 1'b0;
    w_mem_addr_next  = r_mem_addr;
    w_mem_wdata_next = r_mem_wdata;
`ifdef CODE_LOADER_CHECKSUM_EN
    w_csum_next      = r_csum;
`endif
    case (r_state)
      IDLE, DONE, ERR: begin
        if (w_xfer && w_is_sync) begin
          w_state_next = COUNT;
`ifdef CODE_LOADER_CHECKSUM_EN
          w_csum_next  = '0;
`endif
        end
      end
      COUNT: begin
        if (w_xfer) begin
          w_count_next = in_data;
          if (w_bad_count) begin
            w_state_next = ERR;
          end else begin
            w_word_idx_next = '0;
            w_state_next    = DATA;
          end
        end
      end
      DATA: begin
        if (w_xfer) begin
`ifdef CODE_LOADER_CHECKSUM_EN
          w_csum_next = r_csum ^ in_data;
`endif
          if (w_word_ready_c) begin
            w_state_next     = WRITE;
            w_mem_we_next    = 1'b1;
            w_mem_addr_next  = r_word_idx;
            w_mem_wdata_next = w_word_c;
          end
        end
      end
      WRITE: begin
        if (w_last_word) begin
`ifdef CODE_LOADER_CHECKSUM_EN
          w_state_next = CHECK;
`else
          w_state_next = DONE;
`endif
        end else begin
          w_word_idx_next = r_word_idx + CODE_ADDR_WIDTH'(1);
          w_state_next    = DATA;
        end
      end
`ifdef CODE_LOADER_CHECKSUM_EN
      CHECK: begin
        if (w_xfer) begin
          w_state_next = (in_data == r_csum) ? DONE : ERR;
        end
      end
`endif
      default: w_state_next = IDLE;
    endcase
  end

  assign in_ready   = r_in_ready;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign cpu_nreset = r_cpu_nreset;
  assign done       = r_done;
  assign error      = r_error;

endmodule

// File: tb/tb_code_loader.sv
// Self-checking bench for code_loader: directed frames plus randomized frames
// checked against a word-level model of the expected writes and final status.
module tb_code_loader;

  localparam int unsigned CW = 8;
  localparam int unsigned AW = 3;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, mem_we, cpu_nreset, done, error;
  logic [AW-1:0] mem_addr;
  logic [31:0] mem_wdata;

  int total = 0;
  int bad = 0;
  int gap_mode = 0;

  logic [31:0] exp_mem [CW];
  logic [31:0] obs_mem [CW];
  int          obs_addr_q [$];
  logic [31:0] obs_data_q [$];
  int          exp_addr_q [$];
  logic [31:0] exp_data_q [$];
  bit          exp_ok;

  code_loader #(.CODE_WORDS(CW)) dut (
    .clk        (clk),
    .nreset     (nreset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_nreset (cpu_nreset),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Capture every memory write; the loader must not accept bytes while writing.
  always @(negedge clk) begin
    if (nreset && mem_we) begin
      obs_addr_q.push_back(int'(mem_addr));
      obs_data_q.push_back(mem_wdata);
      obs_mem[mem_addr] = mem_wdata;
      check("ready_during_write", 32'(in_ready), 32'd0);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    if (gap_mode == 1) @(negedge clk);
    if (gap_mode == 2) repeat ($urandom_range(0, 2)) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (in_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 20) check("ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic send_junk();
    logic [7:0] j = 8'($urandom);
    if (j == 8'hA5) j = 8'h00;
    send_byte(j);
  endtask

  // Model: a frame with 1..CW words writes them in order from address 0 and
  // succeeds unless its checksum (XOR of payload bytes) is wrong.
  task automatic send_frame(input logic [7:0] n, input logic [31:0] words [$], input bit corrupt);
    logic [7:0] csum = 8'h00;
    logic [7:0] b;
    bit         n_ok = (n >= 8'd1) && (n <= 8'(CW));
    send_byte(8'hA5);
    check("sync_cpu_nreset", 32'(cpu_nreset), 32'd0);
    check("sync_done", 32'(done), 32'd0);
    send_byte(n);
    exp_ok = n_ok;
    if (n_ok) begin
      for (int i = 0; i < int'(n); i++) begin
        for (int j = 0; j < 4; j++) begin
          b = 8'(words[i] >> (8 * j));
          csum ^= b;
          send_byte(b);
        end
        exp_addr_q.push_back(i);
        exp_data_q.push_back(words[i]);
        exp_mem[i] = words[i];
      end
`ifdef CODE_LOADER_CHECKSUM_EN
      send_byte(corrupt ? (csum ^ 8'h01) : csum);
      if (corrupt) exp_ok = 1'b0;
`else
      if (corrupt) exp_ok = n_ok;
`endif
    end
  endtask

  task automatic verify(input string tag);
    int n;
    repeat (3) @(negedge clk);
    check({tag, "_nwrites"}, 32'(obs_addr_q.size()), 32'(exp_addr_q.size()));
    n = (obs_addr_q.size() < exp_addr_q.size()) ? obs_addr_q.size() : exp_addr_q.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_addr"}, 32'(obs_addr_q[i]), 32'(exp_addr_q[i]));
      check({tag, "_data"}, obs_data_q[i], exp_data_q[i]);
    end
    check({tag, "_done"}, 32'(done), 32'(exp_ok));
    check({tag, "_error"}, 32'(error), 32'(!exp_ok));
    check({tag, "_cpu_nreset"}, 32'(cpu_nreset), 32'(exp_ok));
    for (int i = 0; i < int'(CW); i++) check({tag, "_mem"}, obs_mem[i], exp_mem[i]);
    obs_addr_q.delete(); obs_data_q.delete();
    exp_addr_q.delete(); exp_data_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check({tag, "_cpu_nreset"}, 32'(cpu_nreset), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
  endtask

  initial begin
    logic [31:0] w [$];
    logic [7:0]  n;
    int          r;

    for (int i = 0; i < int'(CW); i++) begin
      exp_mem[i] = 32'h0;
      obs_mem[i] = 32'h0;
    end

    // Reset values
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    nreset = 1'b1;
    repeat (2) @(negedge clk);

    // Two-word frame behind junk bytes
    send_byte(8'h00);
    send_byte(8'hFF);
    w = '{32'hE0822001, 32'hEAFFFFFD};
    send_frame(8'd2, w, 1'b0);
    verify("two_word");

`ifdef CODE_LOADER_CHECKSUM_EN
    // Bad checksum, then recovery with a valid frame
    send_frame(8'd2, w, 1'b1);
    verify("bad_csum");
    send_frame(8'd2, w, 1'b0);
    verify("recover");
`endif

    // Bad counts
    send_frame(8'd0, w, 1'b0);
    verify("count_zero");
    send_frame(8'd9, w, 1'b0);
    verify("count_nine");

    // Handshake with in_valid toggling every other cycle
    gap_mode = 1;
    w = '{32'h0BADF00D, 32'hA5A5A5A5};
    send_frame(8'd2, w, 1'b0);
    verify("toggle");
    gap_mode = 0;

    // Asynchronous reset right after the sixth byte (the word is about to be written)
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    nreset = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    @(negedge clk);
    nreset = 1'b1;
    repeat (2) @(negedge clk);
    obs_addr_q.delete(); obs_data_q.delete();
    w = '{32'hE0822001, 32'hEAFFFFFD};
    send_frame(8'd2, w, 1'b0);
    verify("after_reset");

    // Reload from DONE; send_frame checks cpu_nreset drops on the sync transfer
    w = '{32'h11223344};
    send_frame(8'd1, w, 1'b0);
    verify("reload");

    // Randomized frames
    for (int k = 0; k < 30; k++) begin
      gap_mode = int'($urandom_range(0, 2));
      repeat ($urandom_range(0, 2)) send_junk();
      r = int'($urandom_range(0, 9));
      if (r == 0)      n = 8'd0;
      else if (r == 9) n = 8'(9 + $urandom_range(0, 246));
      else             n = 8'($urandom_range(1, CW));
      w.delete();
      for (int i = 0; i < int'(CW); i++) begin
        w.push_back($urandom);
        if ($urandom_range(0, 3) == 0) w[i][15:8] = 8'hA5;
      end
      send_frame(n, w, ($urandom_range(0, 3) == 0));
      verify("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/code_loader.md
Name: code_loader

Overview:
- Writer side of the CPU instruction memory. It fills `code_mem` so the CPU core no longer depends on `initial` blocks.
- Accepts a framed byte stream over a valid/ready handshake, assembles 32-bit little-endian words and writes them sequentially from word 0.
- Holds the CPU in reset through `cpu_nreset` until a complete, valid image has been loaded.
- Sits between a host byte source (UART or debug bridge) and the CPU's code memory write port.

Parameters:
- CODE_WORDS, 8, depth of code memory in 32-bit words. Must match the CPU's `code_words`.
- CODE_ADDR_WIDTH, $clog2(CODE_WORDS), word address width. Derived; never overridden independently.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  in  1  system clock; all state is rising-edge.
- nreset  in  1  asynchronous active-low reset.
- in_valid  in  1  source has a byte on in_data.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts a byte this cycle. A transfer happens when in_valid and in_ready are both high.
- mem_we  out  1  one-cycle code memory write strobe.
- mem_addr  out  CODE_ADDR_WIDTH  word address for the write.
- mem_wdata  out  32  word to write.
- cpu_nreset  out  1  active-low reset to the CPU core.
- done  out  1  a valid image has been loaded.
- error  out  1  the last frame was rejected.

Behaviour:
- Reset: clock is `clk`; reset is `nreset`, asynchronous and active-low. While `nreset` is low:
  - state = IDLE, in_ready = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - cpu_nreset = 0, done = 0, error = 0.
- All outputs are registered. in_ready is 1 in every state except WRITE.
- Frame format: SYNC_BYTE, N (word count), 4*N payload bytes, then a checksum byte (checksum only with the feature enabled).
- Byte order: the first payload byte of each word lands in bits [7:0], the fourth in [31:24].
- States:
  - IDLE: accepted byte == SYNC_BYTE -> COUNT. Any other byte is discarded.
  - COUNT: on transfer, latch N.
    - N == 0 or N > CODE_WORDS -> ERR.
    - Otherwise word_idx = 0, byte_idx = 0 -> DATA.
  - DATA: each transfer shifts the byte into the assembler and increments byte_idx (mod 4).
    - On the 4th byte -> WRITE.
  - WRITE (exactly 1 cycle, in_ready = 0): mem_we = 1, mem_addr = word_idx, mem_wdata = assembled word.
    - If word_idx == N-1 -> CHECK (or DONE when the feature is disabled).
    - Otherwise word_idx+1 -> DATA.
  - CHECK: on transfer, compare the byte with the running XOR of all payload bytes.
    - Match -> DONE.
    - Mismatch -> ERR.
  - DONE: done = 1, error = 0, cpu_nreset = 1.
    - An accepted SYNC_BYTE -> COUNT, and cpu_nreset, done = 0 in the same clock edge (reload).
    - Other bytes are ignored.
  - ERR: error = 1, done = 0, cpu_nreset = 0.
    - An accepted SYNC_BYTE -> COUNT and clears error. Other bytes are ignored.
- Entering COUNT from any state: cpu_nreset = 0, done = 0.
- Words already written by a rejected frame remain in memory. The CPU stays in reset, so they are never executed.
- in_valid low in any state: hold. There is no timeout.
- Payload bytes equal to SYNC_BYTE are data, not resync. Only IDLE, DONE and ERR look for sync.
- Deasserting `nreset` mid-frame aborts the frame immediately. A partially written memory is left as is.
- mem_addr wraps are impossible because N <= CODE_WORDS is checked in COUNT.

Optional Feature:
- Macro: CODE_LOADER_CHECKSUM_EN.
- Defined: the CHECK state and 8-bit XOR accumulator exist. The accumulator is cleared on entering COUNT and updated on every DATA transfer. The frame ends with a checksum byte.
- Undefined: no checksum byte and no CHECK state. WRITE of word N-1 goes directly to DONE, and ERR is reachable only through a bad N.

Decomposition:
- Package code_loader_pkg holds:
  - the state enum (IDLE, COUNT, DATA, WRITE, CHECK, DONE, ERR);
  - the SYNC_BYTE default;
  - the byte-lane index typedef (2 bits).
- One sub-module, word_assembler: shift-in of 8-bit lanes into a 32-bit little-endian word with a 2-bit lane counter and a word_ready pulse. The FSM, counters and checksum stay in code_loader.

Test Plan (the example frame has checksum 0x54, which is the XOR of the 8 payload bytes):
- Load two words, checksum on: stream A5 02 01 20 82 E0 FD FF FF EA 54 -> expect:
  - mem_we at addr 0 with E0822001;
  - mem_we at addr 1 with EAFFFFFD;
  - done = 1, cpu_nreset = 1, error = 0.
- Bad checksum: same stream with last byte 55 -> expect both writes to occur, then error = 1, done = 0, cpu_nreset = 0. A following valid frame -> done = 1, error = 0.
- Bad count: stream A5 00, and separately A5 09 (CODE_WORDS = 8) -> expect error = 1, no mem_we, cpu_nreset = 0.
- Handshake and hold: drive the two-word frame with in_valid toggled every other cycle, and check in_ready = 0 during each WRITE cycle -> expect no lost or duplicated bytes and identical memory contents. Junk bytes 00 FF before A5 in IDLE are ignored.
- Reset mid-frame: assert nreset after the 6th byte -> expect all outputs at reset values immediately (asynchronous). A complete frame after release loads correctly.
- Reload from DONE: after a successful load, send A5 01 44 33 22 11 (checksum 0x44) -> expect cpu_nreset to drop on the A5 transfer, addr 0 to receive 11223344, then cpu_nreset = 1.
